// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Converts the read side of an async FIFO (registered data_out, valid one
// cycle after rd_en) into a valid/ready stream. A two-entry skid buffer
// absorbs the one-cycle read latency, so a full-rate stream is sustained
// while downstream is ready and no word is lost when it stalls.
//
// Optional feature: define FIFO_RD_STREAM_CNT_EN to add the rd_count output,
// a free-running 16-bit count of stream transfers (wraps 0xFFFF -> 0x0000).
//
// Ports
//   rd_clk      in   read-domain clock, rising edge
//   rd_rst      in   asynchronous active-high reset
//   fifo_empty  in   async FIFO empty flag
//   fifo_data   in   async FIFO data_out (valid one cycle after fifo_rd_en)
//   fifo_rd_en  out  read strobe to async FIFO
//   m_data      out  stream data (oldest buffered word)
//   m_valid     out  stream data valid
//   m_ready     in   downstream accept
//   rd_count    out  transfer count (only with FIFO_RD_STREAM_CNT_EN)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);

    // Buffer occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic [DATA_WIDTH-1:0]   head_q, head_d;
    logic [DATA_WIDTH-1:0]   tail_q, tail_d;

    logic [1:0]              occ;
    logic [1:0]              level;     // occupancy + in-flight read - pop
    logic                    push;
    logic                    pop;
    logic                    wr_head;   // incoming word lands in the head slot

    assign occ     = state_q;
    assign push    = pend_q;
    assign m_valid = (state_q != EMPTY);
    assign m_data  = head_q;
    assign pop     = m_valid && m_ready;

    // Only request a new word if, after this cycle's pop, there is room for
    // it alongside any read already in flight. Reset gates the strobe so the
    // FIFO is never read while the buffer is being cleared.
    always_comb begin
        level      = occ + {1'b0, pend_q} - {1'b0, pop};
        fifo_rd_en = !rd_rst && !fifo_empty && (level < 2'd2);
        pend_d     = fifo_rd_en;
    end

    // Next-state logic: occupancy moves by push - pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push) state_d = ONE;
            end
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (!push && pop) state_d = EMPTY;
            end
            TWO: begin
                if (pop && !push) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath: a pop shifts tail into head; the captured word is written to
    // the first free slot as seen after that shift.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        wr_head = (state_q == EMPTY) || ((state_q == ONE) && pop);
        if (pop) begin
            head_d = tail_q;
        end
        if (push) begin
            if (wr_head) head_d = fifo_data;
            else         tail_d = fifo_data;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= EMPTY;
            pend_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] rd_count_q, rd_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        if (pop) rd_count_d = rd_count_q + 16'd1;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) rd_count_q <= 16'd0;
        else        rd_count_q <= rd_count_d;
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Directed bench for fifo_rd_stream. The async FIFO read side is modelled by
// a queue: a word is removed when fifo_rd_en is seen high before an edge and
// appears on fifo_data shortly after that edge. Inputs change on the falling
// edge; outputs are sampled 1 ns after the falling edge, before the next
// rising edge that acts on them.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int DW = 8;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0]   rd_count;
`endif

    fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] q[$];
    logic          s_valid;
    logic          s_rd_en;
    logic [DW-1:0] s_data;
    int            rd_en_pulses = 0;
    int            rd_en_empty_viol = 0;

    task automatic push_word(input logic [DW-1:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: sample, let the rising edge happen, update FIFO model.
    task automatic tick();
        logic take;
        #1;
        s_valid = m_valid;
        s_data  = m_data;
        s_rd_en = fifo_rd_en;
        take    = fifo_rd_en;
        if (fifo_rd_en) rd_en_pulses++;
        if (fifo_rd_en && fifo_empty) rd_en_empty_viol++;
        @(posedge rd_clk);
        #1;
        if (take && q.size() > 0) fifo_data = q.pop_front();
        fifo_empty = (q.size() == 0);
        @(negedge rd_clk);
    endtask

    task automatic test_reset();
        rd_rst  = 1'b1;
        m_ready = 1'b1;
        push_word(8'hAA);
        repeat (2) @(negedge rd_clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", m_data); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
`ifdef FIFO_RD_STREAM_CNT_EN
        checks++; if (rd_count !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h exp=0000", rd_count); end
`endif
        q.delete();
        fifo_empty = 1'b1;
        rd_rst = 1'b0;
        @(negedge rd_clk);
        $display("test_reset done");
    endtask

    task automatic test_three_words();
        logic          exp_v[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] exp_d[6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        m_ready = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) begin
                checks++; if (s_rd_en !== 1'b1) begin errors++; $display("FAIL three_first_rd got=%b exp=1", s_rd_en); end
            end
            checks++; if (s_valid !== exp_v[c]) begin errors++; $display("FAIL three_valid c=%0d got=%b exp=%b", c, s_valid, exp_v[c]); end
            if (exp_v[c]) begin
                checks++; if (s_data !== exp_d[c]) begin errors++; $display("FAIL three_data c=%0d got=%h exp=%h", c, s_data, exp_d[c]); end
            end
            $display("three c=%0d valid=%b data=%h", c, s_valid, s_data);
        end
    endtask

    task automatic test_burst16();
        logic          ev;
        logic [DW-1:0] ed;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(8'(i));
        for (int c = 0; c < 19; c++) begin
            tick();
            ev = (c >= 2) && (c <= 17);
            ed = 8'(c - 2);
            checks++; if (s_valid !== ev) begin errors++; $display("FAIL burst_valid c=%0d got=%b exp=%b", c, s_valid, ev); end
            if (ev) begin
                checks++; if (s_data !== ed) begin errors++; $display("FAIL burst_data c=%0d got=%h exp=%h", c, s_data, ed); end
            end
            $display("burst c=%0d valid=%b data=%h", c, s_valid, s_data);
        end
    endtask

    task automatic test_backpressure();
        rd_en_pulses = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(i));
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c >= 2) begin
                checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, s_valid); end
                checks++; if (s_data !== 8'h00) begin errors++; $display("FAIL bp_hold_data c=%0d got=%h exp=00", c, s_data); end
            end
            $display("bp_stall c=%0d valid=%b data=%h rd_en=%b", c, s_valid, s_data, s_rd_en);
        end
        checks++; if (rd_en_pulses !== 2) begin errors++; $display("FAIL bp_reads_stalled got=%0d exp=2", rd_en_pulses); end
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (s_valid !== (c < 4)) begin errors++; $display("FAIL bp_rel_valid c=%0d got=%b exp=%b", c, s_valid, (c < 4)); end
            if (c < 4) begin
                checks++; if (s_data !== 8'(c)) begin errors++; $display("FAIL bp_rel_data c=%0d got=%h exp=%h", c, s_data, 8'(c)); end
            end
            $display("bp_release c=%0d valid=%b data=%h", c, s_valid, s_data);
        end
        checks++; if (rd_en_pulses !== 4) begin errors++; $display("FAIL bp_reads_total got=%0d exp=4", rd_en_pulses); end
    endtask

    task automatic test_empty_fifo();
        for (int c = 0; c < 8; c++) begin
            m_ready = c[0];
            tick();
            checks++; if (s_rd_en !== 1'b0) begin errors++; $display("FAIL empty_rd_en c=%0d got=%b exp=0", c, s_rd_en); end
            checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL empty_valid c=%0d got=%b exp=0", c, s_valid); end
            $display("empty c=%0d rd_en=%b valid=%b", c, s_rd_en, s_valid);
        end
    endtask

    task automatic test_reset_full_buffer();
        logic          ev;
        logic [DW-1:0] ed;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'(8'h40 + i));
        repeat (4) tick();
        checks++; if (s_valid !== 1'b1 || s_data !== 8'h40 || s_rd_en !== 1'b0) begin
            errors++; $display("FAIL rst_full_pre got=%b/%h/%b exp=1/40/0", s_valid, s_data, s_rd_en);
        end
        #2 rd_rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_full_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_full_data got=%h exp=00", m_data); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_full_rd_en got=%b exp=0", fifo_rd_en); end
        $display("rst_full async reset valid=%b data=%h", m_valid, m_data);
        @(negedge rd_clk);
        rd_rst  = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            ev = (c >= 2) && (c <= 5);
            ed = 8'(8'h42 + c - 2);
            checks++; if (s_valid !== ev) begin errors++; $display("FAIL rst_full_after_valid c=%0d got=%b exp=%b", c, s_valid, ev); end
            if (ev) begin
                checks++; if (s_data !== ed) begin errors++; $display("FAIL rst_full_after_data c=%0d got=%h exp=%h", c, s_data, ed); end
            end
            $display("rst_full after c=%0d valid=%b data=%h", c, s_valid, s_data);
        end
    endtask

`ifdef FIFO_RD_STREAM_CNT_EN
    task automatic test_count();
        int n = 0;
        int bad_data = 0;
        rd_rst = 1'b1;
        #1;
        checks++; if (rd_count !== 16'h0000) begin errors++; $display("FAIL count_reset got=%h exp=0000", rd_count); end
        @(negedge rd_clk);
        rd_rst  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 65537; i++) push_word(8'(i));
        for (int c = 0; c < 65600 && n < 65537; c++) begin
            tick();
            if (s_valid) begin
                if (s_data !== 8'(n)) bad_data++;
                n++;
                if (n == 65535) begin
                    checks++; if (rd_count !== 16'hFFFF) begin errors++; $display("FAIL count_ffff got=%h exp=ffff", rd_count); end
                end
                if (n == 65536) begin
                    checks++; if (rd_count !== 16'h0000) begin errors++; $display("FAIL count_wrap got=%h exp=0000", rd_count); end
                end
            end
        end
        checks++; if (n !== 65537) begin errors++; $display("FAIL count_transfers got=%0d exp=65537", n); end
        checks++; if (bad_data !== 0) begin errors++; $display("FAIL count_order got=%0d bad words exp=0", bad_data); end
        checks++; if (rd_count !== 16'h0001) begin errors++; $display("FAIL count_final got=%h exp=0001", rd_count); end
        $display("count transfers=%0d rd_count=%h", n, rd_count);
    endtask
`endif

    task automatic test_no_empty_reads();
        checks++; if (rd_en_empty_viol !== 0) begin errors++; $display("FAIL rd_en_while_empty got=%0d exp=0", rd_en_empty_viol); end
    endtask

    initial begin
        rd_rst     = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        m_ready    = 1'b0;
        test_reset();
        test_three_words();
        test_burst16();
        test_backpressure();
        test_empty_fifo();
        test_reset_full_buffer();
`ifdef FIFO_RD_STREAM_CNT_EN
        test_count();
`endif
        test_no_empty_reads();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 SHALL have port rd_clk  input  1  read-domain clock, all logic on rising edge.
REQ-003 SHALL have port rd_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port fifo_empty  input  1  empty flag from async_fifo read side.
REQ-005 SHALL have port fifo_data  input  DATA_WIDTH  async_fifo data_out, valid one rd_clk cycle after fifo_rd_en sampled high.
REQ-006 SHALL have port fifo_rd_en  output  1  read strobe to async_fifo rd_en.
REQ-007 SHALL have port m_data  output  DATA_WIDTH  stream data, head of local buffer.
REQ-008 SHALL have port m_valid  output  1  stream data valid.
REQ-009 SHALL have port m_ready  input  1  downstream accept; transfer when m_valid && m_ready at rising edge.

Function
REQ-010 SHALL hold a 2-entry FIFO-ordered local buffer; occupancy occ in {0,1,2}; states EMPTY(occ=0), ONE(occ=1), TWO(occ=2).
REQ-011 SHALL keep pend flag = fifo_rd_en registered; pend=1 means fifo_data is captured into the buffer at the next rising edge.
REQ-012 SHALL define pop = m_valid && m_ready (combinational).
REQ-013 SHALL drive fifo_rd_en = !fifo_empty && (occ + pend - pop) < 2 (combinational); never assert while fifo_empty=1.
REQ-014 SHALL update occ each edge as occ + pend - pop; pend push and pop in the same cycle leave occ unchanged.
REQ-015 SHALL transition EMPTY->ONE on push without pop; ONE->TWO on push without pop; TWO->ONE on pop without push; ONE->EMPTY on pop without push; otherwise hold.
REQ-016 SHALL drive m_valid = (occ != 0) and m_data = oldest buffered entry; m_data SHALL be stable while m_valid && !m_ready.
REQ-017 SHALL deliver data in exact FIFO read order with no loss or duplication.
REQ-018 SHALL sustain one transfer per rd_clk cycle when fifo_empty=0 and m_ready=1 continuously after startup.
REQ-019 SHALL have first-word latency of 2 cycles: fifo_rd_en high at edge N, m_valid high after edge N+1.
REQ-020 SHALL never overflow the local buffer: occ + pend never exceeds 2.
REQ-021 SHALL, when m_ready=0, stop issuing reads once occ + pend = 2 and retain both entries.

Reset
REQ-022 SHALL, on rd_rst=1, immediately force occ=0, pend=0, m_valid=0, m_data=0, fifo_rd_en=0, independent of rd_clk.
REQ-023 SHALL discard buffered and in-flight data when rd_rst asserts mid-operation; first read after release no earlier than first rising edge with rd_rst=0.

Configuration
REQ-024 SHALL, with macro FIFO_RD_STREAM_CNT_EN defined, add output rd_count [15:0] counting pops, reset to 0, wrapping 0xFFFF->0x0000.
REQ-025 SHALL, without FIFO_RD_STREAM_CNT_EN, omit rd_count and its logic; all other behaviour identical.

Verification
REQ-026 SHALL cover: write 0x11,0x22,0x33 into async_fifo, m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, m_valid then low.
REQ-027 SHALL cover: 16 words 0x00..0x0F, m_ready=1 -> 16 back-to-back transfers, no bubble after first word.
REQ-028 SHALL cover: 4 words, m_ready=0 for 10 cycles -> exactly 2 fifo_rd_en pulses, m_data=0x00 stable, then 0x00..0x03 in order on release.
REQ-029 SHALL cover: fifo_empty=1 throughout -> fifo_rd_en never asserts, m_valid=0.
REQ-030 SHALL cover: rd_rst pulse with occ=2 -> m_valid=0 and m_data=0 same cycle; subsequent stream starts with next FIFO word.
REQ-031 SHALL cover with FIFO_RD_STREAM_CNT_EN: 65537 transfers -> rd_count=0x0001.
